// File: rtl/irq_ctrl_pkg.sv
// Shared types and helpers for the interrupt controller.
package irq_ctrl_pkg;

  // Largest number of interrupt sources the controller supports.
  localparam int MAX_SRC = 16;
  localparam int MAX_ID_W = $clog2(MAX_SRC);

  // Handshake state towards proc.
  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } irq_state_e;

  // Convert a one-hot (or all-zero) vector into the index of its set bit.
  function automatic logic [MAX_ID_W-1:0] onehot_to_idx(input logic [MAX_SRC-1:0] oh);
    logic [MAX_ID_W-1:0] idx;
    idx = {MAX_ID_W{1'b0}};
    for (int i = 0; i < MAX_SRC; i++) begin
      idx = idx | (oh[i] ? MAX_ID_W'(i) : {MAX_ID_W{1'b0}});
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_prio_arb.sv
// Combinational priority arbiter: the search starts at index `start` and
// wraps from NUM_SRC-1 back to 0. With start = 0 it is a plain
// lowest-index-wins priority encoder.
module irq_prio_arb
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    start,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id
);

  logic [NUM_SRC-1:0] gnt_oh_s;
  logic               found_s;
  logic               hit_s;

  // Two passes: indices at or above start first, then the wrapped-around low indices.
  always_comb begin
    gnt_oh_s = {NUM_SRC{1'b0}};
    found_s  = 1'b0;
    hit_s    = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      hit_s       = req[i] & (i >= int'(start)) & ~found_s;
      gnt_oh_s[i] = gnt_oh_s[i] | hit_s;
      found_s     = found_s | hit_s;
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      hit_s       = req[i] & (i < int'(start)) & ~found_s;
      gnt_oh_s[i] = gnt_oh_s[i] | hit_s;
      found_s     = found_s | hit_s;
    end
  end

  assign gnt_valid = found_s;
  assign gnt_id    = ID_W'(onehot_to_idx(MAX_SRC'(gnt_oh_s)));

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches per-source events and payloads, masks them,
// arbitrates and presents one interrupt at a time to proc until acknowledged.
// Optional feature macro: IRQ_CTRL_RR_ARB_EN (round-robin arbitration);
// without it arbitration is fixed priority, lowest index wins.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_SRC-1:0]          src_req,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  input  logic                        mask_we,
  input  logic [NUM_SRC-1:0]          mask_wdata,
  output logic                        irq,
  output logic [$clog2(NUM_SRC)-1:0]  irq_id,
  output logic [DATA_W-1:0]           irq_data,
  input  logic                        irq_ack,
  output logic [NUM_SRC-1:0]          pending,
  output logic [NUM_SRC-1:0]          overflow,
  input  logic                        ovf_clr
);

  localparam int ID_W = $clog2(NUM_SRC);

  irq_state_e          state_q, state_d;
  logic                irq_q, irq_d;
  logic [ID_W-1:0]     irq_id_q, irq_id_d;
  logic [DATA_W-1:0]   irq_data_q, irq_data_d;
  logic [NUM_SRC-1:0]  pending_q, pending_d;
  logic [NUM_SRC-1:0]  overflow_q, overflow_d;
  logic [NUM_SRC-1:0]  mask_q, mask_d;
  logic [DATA_W-1:0]   data_q [NUM_SRC];
  logic [DATA_W-1:0]   data_d [NUM_SRC];

  logic                ack_fire_s;
  logic [NUM_SRC-1:0]  ack_vec_s;
  logic [NUM_SRC-1:0]  ovf_set_s;
  logic                cap_s;
  logic [ID_W-1:0]     start_s;
  logic                gnt_valid_s;
  logic [ID_W-1:0]     gnt_id_s;

  // An ack only counts while an interrupt is actually presented.
  assign ack_fire_s = (state_q == PRESENT) & irq_ack;
  assign ack_vec_s  = ack_fire_s ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << irq_id_q)
                                 : {NUM_SRC{1'b0}};

`ifdef IRQ_CTRL_RR_ARB_EN
  logic [ID_W-1:0] ptr_q, ptr_d;

  // Pointer remembers the last acknowledged id; search begins just after it.
  assign ptr_d   = ack_fire_s ? irq_id_q : ptr_q;
  assign start_s = (ptr_q == ID_W'(NUM_SRC-1)) ? {ID_W{1'b0}} : ptr_q + 1'b1;

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= ID_W'(NUM_SRC-1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign start_s = {ID_W{1'b0}};
`endif

  irq_prio_arb #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (pending_q & mask_q),
    .start     (start_s),
    .gnt_valid (gnt_valid_s),
    .gnt_id    (gnt_id_s)
  );

  // Event capture, overflow tracking and mask update per source.
  always_comb begin
    mask_d    = mask_we ? mask_wdata : mask_q;
    pending_d = pending_q;
    ovf_set_s = {NUM_SRC{1'b0}};
    cap_s     = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      // A request is accepted when the slot is free or being freed by this ack.
      cap_s        = src_req[i] & (~pending_q[i] | ack_vec_s[i]);
      pending_d[i] = cap_s | (pending_q[i] & ~ack_vec_s[i]);
      data_d[i]    = cap_s ? src_data[i*DATA_W +: DATA_W] : data_q[i];
      ovf_set_s[i] = src_req[i] & pending_q[i] & ~ack_vec_s[i];
    end
    // A fresh overflow beats a simultaneous clear.
    overflow_d = (ovf_clr ? {NUM_SRC{1'b0}} : overflow_q) | ovf_set_s;
  end

  // Presentation FSM: pick a winner in IDLE, hold it stable until acked.
  always_comb begin
    state_d    = state_q;
    irq_d      = irq_q;
    irq_id_d   = irq_id_q;
    irq_data_d = irq_data_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid_s) begin
          irq_d      = 1'b1;
          irq_id_d   = gnt_id_s;
          irq_data_d = data_q[gnt_id_s];
          state_d    = PRESENT;
        end else begin
          state_d    = IDLE;
        end
      end
      PRESENT: begin
        if (irq_ack) begin
          irq_d   = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = PRESENT;
        end
      end
      default: begin
        irq_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset drops any presented interrupt without an ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      irq_q      <= 1'b0;
      irq_id_q   <= {ID_W{1'b0}};
      irq_data_q <= {DATA_W{1'b0}};
      pending_q  <= {NUM_SRC{1'b0}};
      overflow_q <= {NUM_SRC{1'b0}};
      mask_q     <= {NUM_SRC{1'b1}};
      for (int i = 0; i < NUM_SRC; i++) begin
        data_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      state_q    <= state_d;
      irq_q      <= irq_d;
      irq_id_q   <= irq_id_d;
      irq_data_q <= irq_data_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      mask_q     <= mask_d;
      for (int i = 0; i < NUM_SRC; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign irq      = irq_q;
  assign irq_id   = irq_id_q;
  assign irq_data = irq_data_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed testbench for irq_ctrl (default fixed-priority build, 4 sources, 32-bit data).
`timescale 1ns/1ps
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  src_req;
  logic [127:0] src_data;
  logic        mask_we;
  logic [3:0]  mask_wdata;
  logic        irq;
  logic [1:0]  irq_id;
  logic [31:0] irq_data;
  logic        irq_ack;
  logic [3:0]  pending;
  logic [3:0]  overflow;
  logic        ovf_clr;

  int n_cmp = 0;
  int n_err = 0;

  irq_ctrl #(.NUM_SRC(4), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .src_req(src_req), .src_data(src_data),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .irq(irq), .irq_id(irq_id),
    .irq_data(irq_data), .irq_ack(irq_ack), .pending(pending),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; src_req = 4'b1111;
    for (int i = 0; i < 4; i++) src_data[i*32 +: 32] = 32'h11 * 32'(i);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
      n_cmp++; if (pending !== 4'h0) begin n_err++; $display("FAIL reset_pending: got %h want 0", pending); end
    end
    n_cmp++; if (overflow !== 4'h0) begin n_err++; $display("FAIL reset_overflow: got %h want 0", overflow); end
    n_cmp++; if (irq_id !== 2'd0 || irq_data !== 32'h0) begin n_err++; $display("FAIL reset_id_data: got %0d/%h want 0/0", irq_id, irq_data); end
    rst_n = 1'b1;
    tick();
    src_req = 4'b0000;
    n_cmp++; if (pending !== 4'hF || irq !== 1'b0) begin n_err++; $display("FAIL release_cap: got pend=%h irq=%b want F/0", pending, irq); end
    tick();
    n_cmp++; if (pending !== 4'hF || overflow !== 4'h0) begin n_err++; $display("FAIL release_pend2: got pend=%h ovf=%h want F/0", pending, overflow); end
    // All sources enabled after reset: they drain in index order.
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (irq !== 1'b1 || irq_id !== 2'(i) || irq_data !== 32'h11 * 32'(i)) begin
        n_err++; $display("FAIL drain_%0d: got irq=%b id=%0d data=%h want 1/%0d/%h", i, irq, irq_id, irq_data, i, 32'h11 * 32'(i)); end
      irq_ack = 1'b1; tick(); irq_ack = 1'b0;
      n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL drain_ack_%0d: got irq=%b want 0", i, irq); end
      tick();
    end
    n_cmp++; if (pending !== 4'h0 || irq !== 1'b0) begin n_err++; $display("FAIL drain_done: got pend=%h irq=%b want 0/0", pending, irq); end
  endtask

  task automatic test_single();
    src_req = 4'b0100; src_data[64 +: 32] = 32'hDEAD_BEEF;
    tick(); src_req = 4'b0000;
    n_cmp++; if (pending !== 4'b0100 || irq !== 1'b0) begin n_err++; $display("FAIL single_n1: got pend=%h irq=%b want 4/0", pending, irq); end
    tick();
    n_cmp++; if (irq !== 1'b1 || irq_id !== 2'd2 || irq_data !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL single_n2: got irq=%b id=%0d data=%h want 1/2/deadbeef", irq, irq_id, irq_data); end
    tick();
    n_cmp++; if (irq !== 1'b1 || irq_id !== 2'd2) begin n_err++; $display("FAIL single_hold: got irq=%b id=%0d want 1/2", irq, irq_id); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    n_cmp++; if (irq !== 1'b0 || pending !== 4'h0) begin n_err++; $display("FAIL single_ack: got irq=%b pend=%h want 0/0", irq, pending); end
  endtask

  task automatic test_priority();
    src_req = 4'b1010; src_data[32 +: 32] = 32'h0000_0101; src_data[96 +: 32] = 32'h0000_0303;
    tick(); src_req = 4'b0000;
    tick();
    n_cmp++; if (irq !== 1'b1 || irq_id !== 2'd1 || irq_data !== 32'h101) begin
      n_err++; $display("FAIL prio_first: got irq=%b id=%0d data=%h want 1/1/101", irq, irq_id, irq_data); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    n_cmp++; if (irq !== 1'b0 || pending !== 4'b1000) begin n_err++; $display("FAIL prio_idle: got irq=%b pend=%h want 0/8", irq, pending); end
    tick();
    n_cmp++; if (irq !== 1'b1 || irq_id !== 2'd3 || irq_data !== 32'h303) begin
      n_err++; $display("FAIL prio_second: got irq=%b id=%0d data=%h want 1/3/303", irq, irq_id, irq_data); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    n_cmp++; if (irq !== 1'b0 || pending !== 4'h0) begin n_err++; $display("FAIL prio_done: got irq=%b pend=%h want 0/0", irq, pending); end
  endtask

  task automatic test_overflow();
    src_req = 4'b0001; src_data[0 +: 32] = 32'd1;
    tick();
    src_data[0 +: 32] = 32'd2;
    n_cmp++; if (overflow !== 4'h0 || pending !== 4'b0001) begin n_err++; $display("FAIL ovf_first: got ovf=%h pend=%h want 0/1", overflow, pending); end
    tick(); src_req = 4'b0000;
    n_cmp++; if (overflow !== 4'b0001) begin n_err++; $display("FAIL ovf_set: got %h want 1", overflow); end
    n_cmp++; if (irq !== 1'b1 || irq_id !== 2'd0 || irq_data !== 32'd1) begin
      n_err++; $display("FAIL ovf_keep_first: got irq=%b id=%0d data=%h want 1/0/1", irq, irq_id, irq_data); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    n_cmp++; if (pending !== 4'h0 || overflow !== 4'b0001) begin n_err++; $display("FAIL ovf_sticky: got pend=%h ovf=%h want 0/1", pending, overflow); end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    n_cmp++; if (overflow !== 4'h0) begin n_err++; $display("FAIL ovf_clr: got %h want 0", overflow); end
    // Clear and a new overflow in the same cycle: the set wins.
    src_req = 4'b0001; src_data[0 +: 32] = 32'd3;
    tick();
    ovf_clr = 1'b1;
    tick(); src_req = 4'b0000; ovf_clr = 1'b0;
    n_cmp++; if (overflow !== 4'b0001) begin n_err++; $display("FAIL ovf_set_wins: got %h want 1", overflow); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    n_cmp++; if (overflow !== 4'h0 || pending !== 4'h0 || irq !== 1'b0) begin
      n_err++; $display("FAIL ovf_cleanup: got ovf=%h pend=%h irq=%b want 0/0/0", overflow, pending, irq); end
  endtask

  task automatic test_mask();
    mask_we = 1'b1; mask_wdata = 4'b1110; tick(); mask_we = 1'b0;
    src_req = 4'b0001; src_data[0 +: 32] = 32'h0000_000A;
    tick(); src_req = 4'b0000;
    tick();
    n_cmp++; if (pending !== 4'b0001 || irq !== 1'b0) begin n_err++; $display("FAIL mask_block: got pend=%h irq=%b want 1/0", pending, irq); end
    // Ack while idle must not disturb the pending event.
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    n_cmp++; if (pending !== 4'b0001 || irq !== 1'b0) begin n_err++; $display("FAIL idle_ack: got pend=%h irq=%b want 1/0", pending, irq); end
    mask_we = 1'b1; mask_wdata = 4'b1111; tick(); mask_we = 1'b0;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL unmask_n1: got irq=%b want 0", irq); end
    tick();
    n_cmp++; if (irq !== 1'b1 || irq_id !== 2'd0 || irq_data !== 32'hA) begin
      n_err++; $display("FAIL unmask_n2: got irq=%b id=%0d data=%h want 1/0/a", irq, irq_id, irq_data); end
    // Masking during presentation keeps the interrupt up.
    mask_we = 1'b1; mask_wdata = 4'b0000; tick(); mask_we = 1'b0;
    tick();
    n_cmp++; if (irq !== 1'b1 || irq_id !== 2'd0) begin n_err++; $display("FAIL mask_present: got irq=%b id=%0d want 1/0", irq, irq_id); end
    irq_ack = 1'b1; mask_we = 1'b1; mask_wdata = 4'b1111; tick(); irq_ack = 1'b0; mask_we = 1'b0;
    n_cmp++; if (irq !== 1'b0 || pending !== 4'h0) begin n_err++; $display("FAIL mask_done: got irq=%b pend=%h want 0/0", irq, pending); end
  endtask

  task automatic test_ack_same();
    src_req = 4'b0010; src_data[32 +: 32] = 32'd5;
    tick(); src_req = 4'b0000;
    tick();
    n_cmp++; if (irq !== 1'b1 || irq_id !== 2'd1 || irq_data !== 32'd5) begin
      n_err++; $display("FAIL same_first: got irq=%b id=%0d data=%h want 1/1/5", irq, irq_id, irq_data); end
    irq_ack = 1'b1; src_req = 4'b0010; src_data[32 +: 32] = 32'd7;
    tick(); irq_ack = 1'b0; src_req = 4'b0000;
    n_cmp++; if (irq !== 1'b0 || pending !== 4'b0010 || overflow !== 4'h0) begin
      n_err++; $display("FAIL same_ack: got irq=%b pend=%h ovf=%h want 0/2/0", irq, pending, overflow); end
    tick();
    n_cmp++; if (irq !== 1'b1 || irq_id !== 2'd1 || irq_data !== 32'd7) begin
      n_err++; $display("FAIL same_second: got irq=%b id=%0d data=%h want 1/1/7", irq, irq_id, irq_data); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    n_cmp++; if (pending !== 4'h0 || overflow !== 4'h0) begin n_err++; $display("FAIL same_done: got pend=%h ovf=%h want 0/0", pending, overflow); end
  endtask

  task automatic test_reset_mid();
    src_req = 4'b0100; src_data[64 +: 32] = 32'd9;
    tick(); src_req = 4'b0000;
    tick();
    n_cmp++; if (irq !== 1'b1 || irq_id !== 2'd2) begin n_err++; $display("FAIL mid_present: got irq=%b id=%0d want 1/2", irq, irq_id); end
    rst_n = 1'b0; tick();
    n_cmp++; if (irq !== 1'b0 || pending !== 4'h0 || irq_id !== 2'd0 || irq_data !== 32'h0) begin
      n_err++; $display("FAIL mid_reset: got irq=%b pend=%h id=%0d data=%h want 0/0/0/0", irq, pending, irq_id, irq_data); end
    rst_n = 1'b1; tick(); tick();
    n_cmp++; if (irq !== 1'b0 || pending !== 4'h0) begin n_err++; $display("FAIL mid_after: got irq=%b pend=%h want 0/0", irq, pending); end
  endtask

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Test sequence.
  initial begin
    rst_n = 1'b0; src_req = 4'b0000; src_data = 128'h0; mask_we = 1'b0;
    mask_wdata = 4'b0000; irq_ack = 1'b0; ovf_clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    tick();
    test_priority();
    tick();
    test_overflow();
    tick();
    test_mask();
    tick();
    test_ack_same();
    tick();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
